// File: rtl/pcileech_com_demux.sv
// -----------------------------------------------------------------------------
// pcileech_com_demux
//
// Splits the 64-bit receive stream from pcileech_com into typed channels
// (TLP, CFG, CMD, loopback) ahead of pcileech_fifo. Each word carries a magic
// byte in [31:24] and a type in [17:16]; words with a wrong magic byte or a
// non-routable type are dropped and counted. A single holding register feeds
// all channels, so a stalled channel blocks every channel (no reordering).
//
// Parameters:
//   PARAM_MAGIC         required value of din[31:24]
//   PARAM_STALL_CYCLES  stalled cycles before stall_flag asserts (2..65535)
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   din / din_valid / din_ready  input word handshake (din_ready combinational)
//   dout                         registered copy of the last routed word
//   tlp_/cfg_/cmd_/lb_valid      channel valids (one-hot or zero)
//   tlp_/cfg_/cmd_/lb_ready      channel readys
//   bad_magic_cnt                saturating count of dropped words
//   stall_flag                   held word not accepted for PARAM_STALL_CYCLES
//
// Build option:
//   PCILEECH_COM_DEMUX_LOOPBACK_EN  when defined, type 2 routes to lb_*;
//                                   otherwise type 2 is dropped and counted,
//                                   lb_valid is tied 0 and lb_ready ignored.
// -----------------------------------------------------------------------------
module pcileech_com_demux #(
   parameter logic [7:0]  PARAM_MAGIC        = 8'h77,
   parameter int unsigned PARAM_STALL_CYCLES = 1024
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [63:0] din,
   input  logic        din_valid,
   output logic        din_ready,
   output logic [63:0] dout,
   output logic        tlp_valid,
   output logic        cfg_valid,
   output logic        cmd_valid,
   output logic        lb_valid,
   input  logic        tlp_ready,
   input  logic        cfg_ready,
   input  logic        cmd_ready,
   input  logic        lb_ready,
   output logic [15:0] bad_magic_cnt,
   output logic        stall_flag
);

   localparam logic ST_EMPTY = 1'b0;
   localparam logic ST_FULL  = 1'b1;

   localparam logic [1:0] TYPE_LB = 2'd2;

   localparam logic [15:0] STALL_LIM = 16'(PARAM_STALL_CYCLES);

   logic        state_q, state_d;
   // One-hot channel select, bit index == type field: [0]=TLP [1]=CFG [2]=LB [3]=CMD
   logic [3:0]  chan_q, chan_d;
   logic [63:0] dout_q, dout_d;
   logic [15:0] bad_cnt_q, bad_cnt_d;
   logic [15:0] stall_cnt_q, stall_cnt_d;
   logic        stall_flag_q, stall_flag_d;

   logic        ovalid;
   logic        lb_ready_eff;
   logic        out_xfer;
   logic        accept;
   logic        routable;
   logic        good;

   assign ovalid = (state_q == ST_FULL);

`ifdef PCILEECH_COM_DEMUX_LOOPBACK_EN
   assign lb_ready_eff = lb_ready;
   assign routable     = 1'b1;
`else
   assign lb_ready_eff = 1'b0;
   assign routable     = (din[17:16] != TYPE_LB);
`endif

   // chan_q is only non-zero while FULL, so this is the selected channel's ready gated by ovalid.
   assign out_xfer  = |(chan_q & {cmd_ready, lb_ready_eff, cfg_ready, tlp_ready});
   assign din_ready = !ovalid || out_xfer;
   assign accept    = din_valid && din_ready;
   assign good      = (din[31:24] == PARAM_MAGIC) && routable;

   always_comb begin
      state_d      = state_q;
      chan_d       = chan_q;
      dout_d       = dout_q;
      bad_cnt_d    = bad_cnt_q;
      stall_cnt_d  = stall_cnt_q;
      stall_flag_d = stall_flag_q;

      // A good accept reloads the holding register even while the old word
      // leaves; a dropped word only empties the register if it was draining.
      if (accept && good) begin
         state_d = ST_FULL;
         chan_d  = 4'b0001 << din[17:16];
         dout_d  = din;
      end else if (out_xfer) begin
         state_d = ST_EMPTY;
         chan_d  = '0;
      end

      if (accept && !good && (bad_cnt_q != 16'hFFFF)) begin
         bad_cnt_d = bad_cnt_q + 16'd1;
      end

      // Counter stops at the threshold so it can never wrap back below it.
      if (!ovalid || out_xfer) begin
         stall_cnt_d = '0;
      end else if (stall_cnt_q != STALL_LIM) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end

      if (out_xfer) begin
         stall_flag_d = 1'b0;
      end else if (stall_cnt_d == STALL_LIM) begin
         stall_flag_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_EMPTY;
         chan_q       <= '0;
         dout_q       <= '0;
         bad_cnt_q    <= '0;
         stall_cnt_q  <= '0;
         stall_flag_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         chan_q       <= chan_d;
         dout_q       <= dout_d;
         bad_cnt_q    <= bad_cnt_d;
         stall_cnt_q  <= stall_cnt_d;
         stall_flag_q <= stall_flag_d;
      end
   end

   assign dout          = dout_q;
   assign tlp_valid     = chan_q[0];
   assign cfg_valid     = chan_q[1];
   assign cmd_valid     = chan_q[3];
   assign bad_magic_cnt = bad_cnt_q;
   assign stall_flag    = stall_flag_q;

`ifdef PCILEECH_COM_DEMUX_LOOPBACK_EN
   assign lb_valid = chan_q[2];
`else
   assign lb_valid = 1'b0;
   // Loopback is compiled out: its ready and select bit are intentionally unused.
   logic unused_lb;
   assign unused_lb = lb_ready | chan_q[2];
`endif

endmodule

// File: tb/tb_pcileech_com_demux.sv
module tb_pcileech_com_demux;

   logic        clk;
   logic        rst_n;
   logic [63:0] din;
   logic        din_valid;
   logic        din_ready;
   logic [63:0] dout;
   logic        tlp_valid, cfg_valid, cmd_valid, lb_valid;
   logic        tlp_ready, cfg_ready, cmd_ready, lb_ready;
   logic [15:0] bad_magic_cnt;
   logic        stall_flag;

   int unsigned n_vec;
   int unsigned n_err;

   // {tlp, cfg, cmd, lb}
   logic [3:0] chv;
   assign chv = {tlp_valid, cfg_valid, cmd_valid, lb_valid};

   localparam logic [3:0] V_NONE = 4'b0000;
   localparam logic [3:0] V_TLP  = 4'b1000;
   localparam logic [3:0] V_CFG  = 4'b0100;
   localparam logic [3:0] V_CMD  = 4'b0010;
   localparam logic [3:0] V_LB   = 4'b0001;

   pcileech_com_demux #(
      .PARAM_MAGIC        (8'h77),
      .PARAM_STALL_CYCLES (8)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .din           (din),
      .din_valid     (din_valid),
      .din_ready     (din_ready),
      .dout          (dout),
      .tlp_valid     (tlp_valid),
      .cfg_valid     (cfg_valid),
      .cmd_valid     (cmd_valid),
      .lb_valid      (lb_valid),
      .tlp_ready     (tlp_ready),
      .cfg_ready     (cfg_ready),
      .cmd_ready     (cmd_ready),
      .lb_ready      (lb_ready),
      .bad_magic_cnt (bad_magic_cnt),
      .stall_flag    (stall_flag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [63:0] mkw(input logic [31:0] p, input logic [7:0] m,
                                       input logic [1:0] t, input logic [15:0] a);
      return {p, m, 6'b000000, t, a};
   endfunction

   // Leaves the bench 1 time unit after a rising edge with the DUT out of reset.
   task automatic do_reset;
      din       = '0;
      din_valid = 1'b0;
      tlp_ready = 1'b1;
      cfg_ready = 1'b1;
      cmd_ready = 1'b1;
      lb_ready  = 1'b1;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      din = '0; din_valid = 1'b0;
      tlp_ready = 1'b1; cfg_ready = 1'b1; cmd_ready = 1'b1; lb_ready = 1'b1;
      rst_n = 1'b0;
      @(negedge clk);
      n_vec++;
      if (chv !== V_NONE) begin n_err++; $display("FAIL reset_valids: got %b want %b", chv, V_NONE); end
      n_vec++;
      if (dout !== 64'h0) begin n_err++; $display("FAIL reset_dout: got %h want %h", dout, 64'h0); end
      n_vec++;
      if (bad_magic_cnt !== 16'h0) begin n_err++; $display("FAIL reset_badcnt: got %h want %h", bad_magic_cnt, 16'h0); end
      n_vec++;
      if (stall_flag !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want %b", stall_flag, 1'b0); end
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      n_vec++;
      if (din_ready !== 1'b1) begin n_err++; $display("FAIL reset_din_ready: got %b want %b", din_ready, 1'b1); end
   endtask

   task automatic test_stream;
      logic [63:0] w [4];
      logic [3:0]  e [4];
      do_reset;
      w[0] = mkw(32'h1111_0001, 8'h77, 2'd0, 16'h0A0A); e[0] = V_TLP;
      w[1] = mkw(32'h2222_0002, 8'h77, 2'd1, 16'h0B0B); e[1] = V_CFG;
      w[2] = mkw(32'h3333_0003, 8'h77, 2'd3, 16'h0C0C); e[2] = V_CMD;
      w[3] = mkw(32'h4444_0004, 8'h77, 2'd0, 16'h0D0D); e[3] = V_TLP;
      for (int i = 0; i < 5; i++) begin
         if (i < 4) begin din = w[i]; din_valid = 1'b1; end
         else din_valid = 1'b0;
         @(negedge clk);
         n_vec++;
         if (din_ready !== 1'b1) begin n_err++; $display("FAIL stream_din_ready[%0d]: got %b want 1", i, din_ready); end
         if (i > 0) begin
            n_vec++;
            if (chv !== e[i-1]) begin n_err++; $display("FAIL stream_valid[%0d]: got %b want %b", i-1, chv, e[i-1]); end
            n_vec++;
            if (dout !== w[i-1]) begin n_err++; $display("FAIL stream_dout[%0d]: got %h want %h", i-1, dout, w[i-1]); end
         end else begin
            n_vec++;
            if (chv !== V_NONE) begin n_err++; $display("FAIL stream_idle: got %b want %b", chv, V_NONE); end
         end
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      n_vec++;
      if (chv !== V_NONE) begin n_err++; $display("FAIL stream_drain: got %b want %b", chv, V_NONE); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_hol_block;
      logic [63:0] wc, wt;
      do_reset;
      wc = mkw(32'hC0C0_0001, 8'h77, 2'd1, 16'h1234);
      wt = mkw(32'h7070_0002, 8'h77, 2'd0, 16'h5678);
      cfg_ready = 1'b0;
      din = wc; din_valid = 1'b1;
      @(posedge clk); #1;
      din = wt;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         n_vec++;
         if (chv !== V_CFG) begin n_err++; $display("FAIL hol_cfg_held[%0d]: got %b want %b", k, chv, V_CFG); end
         n_vec++;
         if (din_ready !== 1'b0) begin n_err++; $display("FAIL hol_din_ready_low[%0d]: got %b want 0", k, din_ready); end
         @(posedge clk); #1;
      end
      n_vec++;
      if (dout !== wc) begin n_err++; $display("FAIL hol_dout_cfg: got %h want %h", dout, wc); end
      cfg_ready = 1'b1;
      @(negedge clk);
      n_vec++;
      if (din_ready !== 1'b1) begin n_err++; $display("FAIL hol_din_ready_high: got %b want 1", din_ready); end
      @(posedge clk); #1;
      cfg_ready = 1'b0;
      din_valid = 1'b0;
      @(negedge clk);
      n_vec++;
      if (chv !== V_TLP) begin n_err++; $display("FAIL hol_tlp_next: got %b want %b", chv, V_TLP); end
      n_vec++;
      if (dout !== wt) begin n_err++; $display("FAIL hol_dout_tlp: got %h want %h", dout, wt); end
      @(posedge clk); #1;
      @(negedge clk);
      n_vec++;
      if (chv !== V_NONE) begin n_err++; $display("FAIL hol_drain: got %b want %b", chv, V_NONE); end
      cfg_ready = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_bad_magic;
      logic [63:0] w [6];
      logic [3:0]  e [6];
      do_reset;
      w[0] = mkw(32'hA000_0000, 8'h77, 2'd0, 16'h0001); e[0] = V_TLP;
      w[1] = mkw(32'hA000_0001, 8'h76, 2'd1, 16'h0002); e[1] = V_NONE;
      w[2] = mkw(32'hA000_0002, 8'h76, 2'd3, 16'h0003); e[2] = V_NONE;
      w[3] = mkw(32'hA000_0003, 8'h77, 2'd1, 16'h0004); e[3] = V_CFG;
      w[4] = mkw(32'hA000_0004, 8'h76, 2'd0, 16'h0005); e[4] = V_NONE;
      w[5] = mkw(32'hA000_0005, 8'h77, 2'd3, 16'h0006); e[5] = V_CMD;
      for (int i = 0; i < 7; i++) begin
         if (i < 6) begin din = w[i]; din_valid = 1'b1; end
         else din_valid = 1'b0;
         @(negedge clk);
         if (i > 0) begin
            n_vec++;
            if (chv !== e[i-1]) begin n_err++; $display("FAIL bad_valid[%0d]: got %b want %b", i-1, chv, e[i-1]); end
            if (e[i-1] != V_NONE) begin
               n_vec++;
               if (dout !== w[i-1]) begin n_err++; $display("FAIL bad_dout[%0d]: got %h want %h", i-1, dout, w[i-1]); end
            end
         end
         @(posedge clk); #1;
      end
      n_vec++;
      if (bad_magic_cnt !== 16'd3) begin n_err++; $display("FAIL bad_count: got %0d want 3", bad_magic_cnt); end
   endtask

   task automatic test_saturation;
      do_reset;
      din = mkw(32'hDEAD_BEEF, 8'h76, 2'd0, 16'h0000);
      din_valid = 1'b1;
      repeat (65534) @(posedge clk);
      @(negedge clk);
      n_vec++;
      if (bad_magic_cnt !== 16'hFFFE) begin n_err++; $display("FAIL sat_fffe: got %h want %h", bad_magic_cnt, 16'hFFFE); end
      n_vec++;
      if (chv !== V_NONE) begin n_err++; $display("FAIL sat_no_valid: got %b want %b", chv, V_NONE); end
      repeat (6) @(posedge clk);
      @(negedge clk);
      n_vec++;
      if (bad_magic_cnt !== 16'hFFFF) begin n_err++; $display("FAIL sat_ffff: got %h want %h", bad_magic_cnt, 16'hFFFF); end
      din_valid = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_loopback;
      logic [63:0] wt, wl;
      do_reset;
      wt = mkw(32'h5555_0000, 8'h77, 2'd0, 16'h00AA);
      wl = mkw(32'h6666_0000, 8'h77, 2'd2, 16'h00BB);
      din = wt; din_valid = 1'b1;
      @(posedge clk); #1;
      din = wl;
      @(posedge clk); #1;
      din_valid = 1'b0;
      @(negedge clk);
`ifdef PCILEECH_COM_DEMUX_LOOPBACK_EN
      n_vec++;
      if (chv !== V_LB) begin n_err++; $display("FAIL lb_valid: got %b want %b", chv, V_LB); end
      n_vec++;
      if (dout !== wl) begin n_err++; $display("FAIL lb_dout: got %h want %h", dout, wl); end
      n_vec++;
      if (bad_magic_cnt !== 16'd0) begin n_err++; $display("FAIL lb_badcnt: got %0d want 0", bad_magic_cnt); end
`else
      n_vec++;
      if (chv !== V_NONE) begin n_err++; $display("FAIL lb_dropped: got %b want %b", chv, V_NONE); end
      n_vec++;
      if (dout !== wt) begin n_err++; $display("FAIL lb_dout_kept: got %h want %h", dout, wt); end
      n_vec++;
      if (bad_magic_cnt !== 16'd1) begin n_err++; $display("FAIL lb_badcnt: got %0d want 1", bad_magic_cnt); end
`endif
      @(posedge clk); #1;
      @(negedge clk);
      n_vec++;
      if (chv !== V_NONE) begin n_err++; $display("FAIL lb_drain: got %b want %b", chv, V_NONE); end
      @(posedge clk); #1;
   endtask

   task automatic test_stall;
      logic [63:0] wt;
      do_reset;
      wt = mkw(32'h9999_0000, 8'h77, 2'd0, 16'h0077);
      tlp_ready = 1'b0;
      din = wt; din_valid = 1'b1;
      @(posedge clk); #1;
      din_valid = 1'b0;
      repeat (7) @(posedge clk);
      @(negedge clk);
      n_vec++;
      if (stall_flag !== 1'b0) begin n_err++; $display("FAIL stall_7: got %b want 0", stall_flag); end
      @(posedge clk);
      @(negedge clk);
      n_vec++;
      if (stall_flag !== 1'b1) begin n_err++; $display("FAIL stall_8: got %b want 1", stall_flag); end
      n_vec++;
      if (chv !== V_TLP) begin n_err++; $display("FAIL stall_held: got %b want %b", chv, V_TLP); end
      tlp_ready = 1'b1;
      @(posedge clk); #1;
      tlp_ready = 1'b0;
      @(negedge clk);
      n_vec++;
      if (stall_flag !== 1'b0) begin n_err++; $display("FAIL stall_clear: got %b want 0", stall_flag); end

      // Second stall, with a dropped word first so every counter is non-zero before reset.
      @(posedge clk); #1;
      din = mkw(32'h0, 8'h76, 2'd0, 16'h0); din_valid = 1'b1;
      @(posedge clk); #1;
      din = wt;
      @(posedge clk); #1;
      din_valid = 1'b0;
      repeat (9) @(posedge clk);
      #2;
      n_vec++;
      if (stall_flag !== 1'b1) begin n_err++; $display("FAIL stall_pre_reset: got %b want 1", stall_flag); end
      rst_n = 1'b0;
      #1;
      n_vec++;
      if (chv !== V_NONE) begin n_err++; $display("FAIL async_valid: got %b want %b", chv, V_NONE); end
      n_vec++;
      if (dout !== 64'h0) begin n_err++; $display("FAIL async_dout: got %h want 0", dout); end
      n_vec++;
      if (stall_flag !== 1'b0) begin n_err++; $display("FAIL async_stall: got %b want 0", stall_flag); end
      n_vec++;
      if (bad_magic_cnt !== 16'h0) begin n_err++; $display("FAIL async_badcnt: got %h want 0", bad_magic_cnt); end
      @(negedge clk);
      rst_n = 1'b1;
      tlp_ready = 1'b1;
      @(posedge clk); #1;
      n_vec++;
      if (chv !== V_NONE) begin n_err++; $display("FAIL async_word_lost: got %b want %b", chv, V_NONE); end
      n_vec++;
      if (din_ready !== 1'b1) begin n_err++; $display("FAIL async_din_ready: got %b want 1", din_ready); end
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      rst_n = 1'b0;
      test_reset;
      test_stream;
      test_hol_block;
      test_bad_magic;
      test_loopback;
      test_stall;
      test_saturation;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
